key_debounce: RTL and testbench
===============================

Name: key_debounce

Overview:
- Upstream input stage for the board's LED logic.
- Takes raw, bouncing, active-low push-button inputs and synchronises each one to CLK.
- Debounces each key independently and produces a clean level, single-cycle press/release pulses and a long-press pulse.
- The LED rotator consumes key_press/key_long as step/mode controls instead of free-running on its 1 s counter.

Parameters:
- N_KEY, 4, number of independent keys.
- DEB_CYCLES, 500_000, consecutive stable synchronised samples required to accept a level change (20 ms at 25 MHz); legal range 2..2^24.
- LONG_CYCLES, 25_000_000, cycles a key must be held pressed, counted from the accepted press, before key_long fires (1 s at 25 MHz); must be > DEB_CYCLES.

Ports:
- CLK  input  1  system clock, 25 MHz.
- RSTB  input  1  asynchronous active-low reset.
- KEY_N  input  N_KEY  raw buttons, active-low, asynchronous to CLK.
- key_state  output  N_KEY  debounced level, 1 = pressed.
- key_press  output  N_KEY  1-cycle pulse on accepted press.
- key_release  output  N_KEY  1-cycle pulse on accepted release.
- key_long  output  N_KEY  1-cycle pulse once per hold when the hold reaches LONG_CYCLES.

Behaviour:
- Interface: one clock, CLK. RSTB is asynchronous assert, active-low, applied to every flop.
- Reset values:
  - All outputs 0.
  - Synchroniser flops 1 (released).
  - All FSMs in IDLE.
  - All counters 0.
- Synchroniser:
  - 2-flop chain per key; key_s = second flop, inverted so that 1 = pressed.
  - key_s lags KEY_N by 2 edges.
- Per-key FSM, all outputs registered:
  - IDLE: if key_s=1, go to P_WAIT with deb_cnt=1. Otherwise stay.
  - P_WAIT:
    - key_s=0: go to IDLE, deb_cnt=0 (bounce rejected, no pulse).
    - deb_cnt==DEB_CYCLES-1 with key_s=1: go to PRESSED. key_state=1, key_press=1 for one cycle, deb_cnt=0, long_cnt=0.
    - Otherwise deb_cnt++.
  - PRESSED:
    - long_cnt increments each cycle and saturates at LONG_CYCLES.
    - key_long=1 for exactly one cycle on the edge where long_cnt goes from LONG_CYCLES-1 to LONG_CYCLES.
    - If key_s=0: go to R_WAIT with deb_cnt=1. long_cnt keeps counting in R_WAIT.
  - R_WAIT:
    - key_s=1: return to PRESSED, deb_cnt=0, long_cnt not cleared, no pulse.
    - deb_cnt==DEB_CYCLES-1 with key_s=0: go to IDLE. key_state=0, key_release=1 for one cycle, deb_cnt=0, long_cnt=0.
    - Otherwise deb_cnt++.
- Latency: a stable edge on KEY_N produces its press/release pulse, and the key_state change, exactly DEB_CYCLES+2 edges after the first edge that samples the new KEY_N level.
- key_long fires at most once per accepted press. It never fires after key_release, nor in the same cycle as key_release.
- Pulse exclusivity: key_press, key_release and key_long are mutually exclusive per key in any cycle.
- Counter widths are $clog2(DEB_CYCLES+1) and $clog2(LONG_CYCLES+1). No wrap: long_cnt saturates, and deb_cnt is bounded by the FSM.
- Keys are fully independent. Simultaneous events on different keys produce simultaneous pulses on their bits.
- RSTB asserted mid-debounce or mid-hold:
  - Immediately clears all outputs, including any pulse in progress.
  - After release the FSM restarts in IDLE. A key still held then re-debounces and yields a fresh key_press.
- Glitches shorter than DEB_CYCLES consecutive samples never change key_state.

Test Plan (DEB_CYCLES=4, LONG_CYCLES=20, N_KEY=4):
- Clean press: KEY_N[0] driven 1→0 and held -> key_press[0]=1 for exactly one cycle, 6 edges after the first low sample. key_state[0]=1 from that edge. Other bits stay 0.
- Bounce reject: KEY_N[1] low 3 cycles, high 1 cycle, low 2 cycles, then high -> no key_press[1], and key_state[1] stays 0. A subsequent 10-cycle low -> exactly one key_press[1].
- Long press: hold KEY_N[2] low for 40 cycles, then release -> key_press at +6, key_long exactly once 20 cycles after key_press, key_release 6 edges after the first high sample. No second key_long.
- Release bounce: while key 0 is held past key_long, toggle KEY_N[0] high 2 cycles then low -> no key_release and no new key_long; key_state stays 1.
- Simultaneous keys: KEY_N[3:0] 1111→0000 on the same edge -> key_press=4'b1111 in a single cycle; after release, key_release=4'b1111 in a single cycle.
- Reset mid-hold: assert RSTB while key 1 is pressed at long_cnt=10 -> all outputs 0 asynchronously. Deassert with the key still low -> new key_press[1] 6 edges after the first low sample, and key_long 20 cycles after that.

Source files
------------

// File: rtl/key_debounce.sv
// Per-key synchronise + debounce for active-low push buttons: clean level,
// single-cycle press/release pulses and a once-per-hold long-press pulse.
`timescale 1ns/1ps

module key_debounce_chan #(
  parameter int unsigned DEB_CYCLES  = 500_000,
  parameter int unsigned LONG_CYCLES = 25_000_000
) (
  input  logic CLK,
  input  logic RSTB,
  input  logic key_n,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int unsigned DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int unsigned LONG_W = $clog2(LONG_CYCLES + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    P_WAIT,
    PRESSED,
    R_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        sync_q;
  logic              key_s;
  logic [DEB_W-1:0]  deb_q, deb_d;
  logic [LONG_W-1:0] long_q, long_d, long_step;
  logic              long_hit;
  logic              level_d, press_d, release_d, long_d_pulse;

  // Two-flop synchroniser; the released level is the safe reset value.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_n};
    end
  end

  assign key_s = ~sync_q[1];

  // Hold counter saturates so key_long can fire only once per hold.
  assign long_step = (long_q == LONG_MAX) ? long_q : long_q + LONG_W'(1);
  assign long_hit  = (long_q == LONG_LAST);

  // NOTE: every always_comb output gets a default first, so no branch can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    deb_d        = deb_q;
    long_d       = long_q;
    level_d      = key_state;
    press_d      = 1'b0;
    release_d    = 1'b0;
    long_d_pulse = 1'b0;

    case (state_q)
      IDLE: begin
        if (key_s) begin
          state_d = P_WAIT;
          deb_d   = DEB_W'(1);
        end
      end

      P_WAIT: begin
        if (!key_s) begin
          state_d = IDLE;
          deb_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d = PRESSED;
          level_d = 1'b1;
          press_d = 1'b1;
          deb_d   = '0;
          long_d  = '0;
        end else begin
          deb_d = deb_q + DEB_W'(1);
        end
      end

      PRESSED: begin
        long_d       = long_step;
        long_d_pulse = long_hit;
        if (!key_s) begin
          state_d = R_WAIT;
          deb_d   = DEB_W'(1);
        end
      end

      R_WAIT: begin
        if (key_s) begin
          state_d      = PRESSED;
          deb_d        = '0;
          long_d       = long_step;
          long_d_pulse = long_hit;
        end else if (deb_q == DEB_LAST) begin
          // Accepted release wins over a coinciding long-press edge.
          state_d   = IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
          deb_d     = '0;
          long_d    = '0;
        end else begin
          deb_d        = deb_q + DEB_W'(1);
          long_d       = long_step;
          long_d_pulse = long_hit;
        end
      end

      default: begin
        state_d = IDLE;
        deb_d   = '0;
        long_d  = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q     <= IDLE;
      deb_q       <= '0;
      long_q      <= '0;
      key_state   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_q       <= deb_d;
      long_q      <= long_d;
      key_state   <= level_d;
      key_press   <= press_d;
      key_release <= release_d;
      key_long    <= long_d_pulse;
    end
  end

endmodule

module key_debounce #(
  parameter int unsigned N_KEY       = 4,
  parameter int unsigned DEB_CYCLES  = 500_000,
  parameter int unsigned LONG_CYCLES = 25_000_000
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic [N_KEY-1:0] KEY_N,
  output logic [N_KEY-1:0] key_state,
  output logic [N_KEY-1:0] key_press,
  output logic [N_KEY-1:0] key_release,
  output logic [N_KEY-1:0] key_long
);

  // Keys share nothing but clock and reset.
  for (genvar k = 0; k < N_KEY; k++) begin : g_key
    key_debounce_chan #(
      .DEB_CYCLES (DEB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_chan (
      .CLK        (CLK),
      .RSTB       (RSTB),
      .key_n      (KEY_N[k]),
      .key_state  (key_state[k]),
      .key_press  (key_press[k]),
      .key_release(key_release[k]),
      .key_long   (key_long[k])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: table of KEY_N segments with hand-derived pulse
// times feeding a cycle-stamped scoreboard, plus reset corner sequences.
`timescale 1ns/1ps

module tb_key_debounce;

  localparam int unsigned N_KEY       = 4;
  localparam int unsigned DEB_CYCLES  = 4;
  localparam int unsigned LONG_CYCLES = 20;
  // Pulse appears on the 6th edge counting the first sampling edge as 1;
  // inputs are driven just after edge c, so that is edge c+6.
  localparam int LAT  = DEB_CYCLES + 2;
  localparam int LONG = LAT + LONG_CYCLES;

  logic             CLK;
  logic             RSTB;
  logic [N_KEY-1:0] KEY_N;
  logic [N_KEY-1:0] key_state, key_press, key_release, key_long;

  key_debounce #(
    .N_KEY      (N_KEY),
    .DEB_CYCLES (DEB_CYCLES),
    .LONG_CYCLES(LONG_CYCLES)
  ) dut (
    .CLK        (CLK),
    .RSTB       (RSTB),
    .KEY_N      (KEY_N),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  initial begin
    CLK = 1'b0;
    forever #20 CLK = ~CLK;
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;
  string cur_name = "reset";

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h (state|press|release|long)", name, cyc, act, exp);
    end
  endtask

  // Scoreboard of expected pulses, kept sorted by cycle.
  typedef struct {
    int         at;
    logic [3:0] p;
    logic [3:0] r;
    logic [3:0] l;
  } ev_t;
  ev_t evq[$];

  task automatic push_ev(input int at, input logic [3:0] p, input logic [3:0] r, input logic [3:0] l);
    ev_t e;
    int  idx;
    if (p == 4'b0 && r == 4'b0 && l == 4'b0) return;
    idx = 0;
    while (idx < evq.size() && evq[idx].at < at) idx++;
    if (idx < evq.size() && evq[idx].at == at) begin
      evq[idx].p = evq[idx].p | p;
      evq[idx].r = evq[idx].r | r;
      evq[idx].l = evq[idx].l | l;
    end else begin
      e.at = at;
      e.p  = p;
      e.r  = r;
      e.l  = l;
      evq.insert(idx, e);
    end
  endtask

  // Monitor: every cycle compares all outputs against the scoreboard.
  logic       mon_en = 1'b0;
  logic [3:0] exp_state = 4'b0;
  logic [3:0] m_p, m_r, m_l;
  ev_t        m_e;

  always begin
    @(posedge CLK);
    #2;
    if (mon_en) begin
      m_p = 4'b0;
      m_r = 4'b0;
      m_l = 4'b0;
      while (evq.size() > 0 && evq[0].at < cyc) begin
        m_e = evq.pop_front();
        check({cur_name, "/stale_event"}, 16'(cyc), 16'(m_e.at));
      end
      if (!RSTB) begin
        exp_state = 4'b0;
      end else if (evq.size() > 0 && evq[0].at == cyc) begin
        m_e = evq.pop_front();
        m_p = m_e.p;
        m_r = m_e.r;
        m_l = m_e.l;
      end
      exp_state = (exp_state | m_p) & ~m_r;
      check({cur_name, "/outputs"}, {key_state, key_press, key_release, key_long},
            {exp_state, m_p, m_r, m_l});
    end
  end

  typedef struct {
    string      name;
    logic [3:0] key_n;
    int         len;
    logic [3:0] p;   // press at drive+LAT
    logic [3:0] r;   // release at drive+LAT
    logic [3:0] l;   // long at drive+LONG
  } row_t;
  row_t rows[$];

  task automatic add(input string n, input logic [3:0] k, input int len,
                     input logic [3:0] p, input logic [3:0] r, input logic [3:0] l);
    row_t x;
    x.name = n; x.key_n = k; x.len = len; x.p = p; x.r = r; x.l = l;
    rows.push_back(x);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100_000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  int c, d, r;

  initial begin
    RSTB  = 1'b1;
    KEY_N = 4'b1111;
    #3 RSTB = 1'b0;
    #5;
    check("reset_values", {key_state, key_press, key_release, key_long}, 16'h0000);
    repeat (3) tick();
    RSTB   = 1'b1;
    mon_en = 1'b1;
    repeat (4) tick();

    add("k0_press",     4'b1110, 30, 4'b0001, 4'b0000, 4'b0001);
    add("k0_bounce_hi", 4'b1111,  2, 4'b0000, 4'b0000, 4'b0000);
    add("k0_relow",     4'b1110, 10, 4'b0000, 4'b0000, 4'b0000);
    add("k0_release",   4'b1111, 12, 4'b0000, 4'b0001, 4'b0000);
    add("k1_low3",      4'b1101,  3, 4'b0000, 4'b0000, 4'b0000);
    add("k1_hi1",       4'b1111,  1, 4'b0000, 4'b0000, 4'b0000);
    add("k1_low2",      4'b1101,  2, 4'b0000, 4'b0000, 4'b0000);
    add("k1_idle",      4'b1111,  8, 4'b0000, 4'b0000, 4'b0000);
    add("k1_press10",   4'b1101, 10, 4'b0010, 4'b0000, 4'b0000);
    add("k1_release",   4'b1111, 12, 4'b0000, 4'b0010, 4'b0000);
    add("k2_long",      4'b1011, 40, 4'b0100, 4'b0000, 4'b0100);
    add("k2_release",   4'b1111, 12, 4'b0000, 4'b0100, 4'b0000);
    add("all_press",    4'b0000, 10, 4'b1111, 4'b0000, 4'b0000);
    add("all_release",  4'b1111, 12, 4'b0000, 4'b1111, 4'b0000);
    add("k3_min_hold",  4'b0111,  4, 4'b1000, 4'b0000, 4'b0000);
    add("k3_min_rel",   4'b1111, 12, 4'b0000, 4'b1000, 4'b0000);
    add("k3_hold20",    4'b0111, 20, 4'b1000, 4'b0000, 4'b0000);
    add("k3_rel20",     4'b1111, 12, 4'b0000, 4'b1000, 4'b0000);
    add("k3_hold21",    4'b0111, 21, 4'b1000, 4'b0000, 4'b1000);
    add("k3_rel21",     4'b1111, 12, 4'b0000, 4'b1000, 4'b0000);

    foreach (rows[i]) begin
      cur_name = rows[i].name;
      KEY_N    = rows[i].key_n;
      c        = cyc;
      push_ev(c + LAT, rows[i].p, rows[i].r, 4'b0000);
      push_ev(c + LONG, 4'b0000, 4'b0000, rows[i].l);
      repeat (rows[i].len) tick();
    end

    // Reset while key 1 is held with its hold counter at 10.
    cur_name = "k1_reset_midhold";
    KEY_N    = 4'b1101;
    c        = cyc;
    push_ev(c + LAT, 4'b0010, 4'b0000, 4'b0000);
    repeat (LAT + 10) tick();
    RSTB = 1'b0;
    #1;
    check("k1_reset_async", {key_state, key_press, key_release, key_long}, 16'h0000);
    repeat (3) tick();
    cur_name = "k1_after_reset";
    RSTB     = 1'b1;
    d        = cyc;
    push_ev(d + LAT, 4'b0010, 4'b0000, 4'b0000);
    push_ev(d + LONG, 4'b0000, 4'b0000, 4'b0010);
    repeat (30) tick();
    KEY_N = 4'b1111;
    r     = cyc;
    push_ev(r + LAT, 4'b0000, 4'b0010, 4'b0000);
    repeat (12) tick();

    // Reset landing while a press pulse is high.
    cur_name = "k3_reset_pulse";
    KEY_N    = 4'b0111;
    c        = cyc;
    push_ev(c + LAT, 4'b1000, 4'b0000, 4'b0000);
    repeat (LAT) tick();
    #2;
    RSTB = 1'b0;
    #1;
    check("k3_reset_clears_pulse", {key_state, key_press, key_release, key_long}, 16'h0000);
    KEY_N = 4'b1111;
    repeat (2) tick();
    RSTB     = 1'b1;
    cur_name = "quiet_tail";
    repeat (10) tick();

    check("events_drained", 16'(evq.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
